// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative RV32M multiply/divide unit (muldiv_unit).
// Operation codes follow the funct3 encoding of the M extension.
package muldiv_unit_pkg;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Bit 2 of the code separates the divide group from the multiply group.
  function automatic logic op_is_div(input md_op_e op);
    return op[2];
  endfunction

  // Within the divide group, bit 1 selects the remainder.
  function automatic logic op_is_rem(input md_op_e op);
    return op[2] & op[1];
  endfunction

  // Whether rs1 is treated as a signed value.
  function automatic logic op_a_signed(input md_op_e op);
    return op[2] ? ~op[0] : (op != MD_MULHU);
  endfunction

  // Whether rs2 is treated as a signed value.
  function automatic logic op_b_signed(input md_op_e op);
    return op[2] ? ~op[0] : ~op[1];
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the muldiv_unit datapath.
//   Multiply: shift-add, accumulator = {partial product, remaining multiplier}.
//   Divide:   restoring step, accumulator = {partial remainder, dividend/quotient}.
// In divide mode acc_o[0] is left clear; the caller inserts q_bit_o there.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              div_mode_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   operand_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              q_bit_o
);

  logic [XLEN:0] sum;
  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Single shift-add or shift-subtract iteration.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    sum     = '0;
    rem_sh  = '0;
    diff    = '0;
    acc_o   = acc_i;
    q_bit_o = 1'b0;
    if (div_mode_i) begin
      rem_sh = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
      diff   = rem_sh - {1'b0, operand_i};
      if (!diff[XLEN]) begin
        q_bit_o = 1'b1;
        acc_o   = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end else begin
        acc_o   = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end
    end else begin
      sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, operand_i} : '0);
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit, XLEN bits wide.
// Magnitudes are processed by muldiv_step for XLEN cycles and the sign is
// fixed up on the last iteration. Divide-by-zero and signed overflow are
// resolved at accept time and skip the iteration.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies use a combinational
// product and complete in one cycle; divides still iterate.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero_flag,
  output logic            negative_flag,
  output logic            busy
);

  localparam int              CNT_W    = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  // Registered state
  md_state_e         state_q;
  md_op_e            op_q;
  logic              res_neg_q;
  logic [XLEN-1:0]   operand_q;
  logic [2*XLEN-1:0] acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [XLEN-1:0]   result_q;
  logic              zero_q;
  logic              neg_q;
  logic              out_valid_q;

  // Accept-time decode
  md_op_e          op_in;
  logic            in_is_div;
  logic            a_neg;
  logic            b_neg;
  logic            in_res_neg;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            special;
  logic [XLEN-1:0] special_res;
  logic            fast_take;
  logic [XLEN-1:0] fast_res;
  logic            direct_done;

  // Iteration and fix-up
  logic [2*XLEN-1:0] step_acc;
  logic              step_q_bit;
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_val;
  logic [XLEN-1:0]   div_fix;
  logic [XLEN-1:0]   calc_res;
  logic [XLEN-1:0]   done_val;

  assign op_in = md_op_e'(op);

  // Operand signs, magnitudes and the special-case results seen at accept.
  always_comb begin
    in_is_div   = op_is_div(op_in);
    a_neg       = op_a_signed(op_in) & src_a[XLEN-1];
    b_neg       = op_b_signed(op_in) & src_b[XLEN-1];
    mag_a       = a_neg ? (~src_a + 1'b1) : src_a;
    mag_b       = b_neg ? (~src_b + 1'b1) : src_b;
    // A remainder takes the dividend's sign; everything else takes a^b.
    in_res_neg  = op_is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
    special     = 1'b0;
    special_res = '0;
    if (in_is_div && (src_b == '0)) begin
      special     = 1'b1;
      special_res = op_is_rem(op_in) ? src_a : '1;
    end else if (in_is_div && op_a_signed(op_in) &&
                 (src_a == MIN_NEG) && (src_b == '1)) begin
      special     = 1'b1;
      special_res = op_is_rem(op_in) ? '0 : src_a;
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  // Sign-extending both operands to 2*XLEN gives the same low 2*XLEN bits as
  // the signed (XLEN+1)x(XLEN+1) product.
  logic [2*XLEN-1:0] fast_a;
  logic [2*XLEN-1:0] fast_b;
  logic [2*XLEN-1:0] fast_prod;

  assign fast_a    = {{XLEN{op_a_signed(op_in) & src_a[XLEN-1]}}, src_a};
  assign fast_b    = {{XLEN{op_b_signed(op_in) & src_b[XLEN-1]}}, src_b};
  assign fast_prod = fast_a * fast_b;
  assign fast_take = !in_is_div;
  assign fast_res  = (op_in == MD_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`else
  assign fast_take = 1'b0;
  assign fast_res  = '0;
`endif

  assign direct_done = special | fast_take;

  muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .div_mode_i(op_is_div(op_q)),
    .acc_i     (acc_q),
    .operand_i (operand_q),
    .acc_o     (step_acc),
    .q_bit_o   (step_q_bit)
  );

  assign acc_nxt = {step_acc[2*XLEN-1:1], step_acc[0] | step_q_bit};

  // Sign fix-up of the final iteration and selection of the value to register.
  always_comb begin
    prod_fix = res_neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
    div_val  = op_is_rem(op_q) ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    div_fix  = res_neg_q ? (~div_val + 1'b1) : div_val;
    if (op_is_div(op_q)) begin
      calc_res = div_fix;
    end else if (op_q == MD_MUL) begin
      calc_res = prod_fix[XLEN-1:0];
    end else begin
      calc_res = prod_fix[2*XLEN-1:XLEN];
    end
    done_val = calc_res;
    if (state_q == MD_IDLE) begin
      done_val = special ? special_res : fast_res;
    end
  end

  // Control FSM with operand, accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= MD_IDLE;
      op_q        <= MD_MUL;
      res_neg_q   <= 1'b0;
      operand_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q     <= MD_IDLE;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (in_valid) begin
            op_q      <= op_in;
            res_neg_q <= in_res_neg;
            operand_q <= mag_b;
            acc_q     <= {{XLEN{1'b0}}, mag_a};
            cnt_q     <= '0;
            if (direct_done) begin
              result_q    <= done_val;
              zero_q      <= (done_val == '0);
              neg_q       <= done_val[XLEN-1];
              out_valid_q <= 1'b1;
              state_q     <= MD_DONE;
            end else begin
              state_q     <= MD_CALC;
            end
          end
        end
        MD_CALC: begin
          acc_q <= acc_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result_q    <= done_val;
            zero_q      <= (done_val == '0);
            neg_q       <= done_val[XLEN-1];
            out_valid_q <= 1'b1;
            state_q     <= MD_DONE;
          end
        end
        MD_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= MD_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= MD_IDLE;
        end
      endcase
    end
  end

  assign in_ready      = (state_q == MD_IDLE);
  assign busy          = (state_q != MD_IDLE);
  assign out_valid     = out_valid_q;
  assign result        = result_q;
  assign zero_flag     = zero_q;
  assign negative_flag = neg_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard testbench for muldiv_unit (XLEN=32). Expected results and
// latencies come from a reference model using native 64-bit arithmetic.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int XLEN = 32;

  typedef struct {
    logic [XLEN-1:0] res;
    int              lat;
  } sb_entry_t;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero_flag;
  logic            negative_flag;
  logic            busy;

  sb_entry_t sb_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(
    .XLEN(XLEN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .op           (op),
    .src_a        (src_a),
    .src_b        (src_b),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .zero_flag    (zero_flag),
    .negative_flag(negative_flag),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] model(input logic [2:0] o, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [63:0] p;
    int          sa;
    int          sbv;
    logic        ovf;
    sa  = a;
    sbv = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b};       return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b};             return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sbv));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'h0 : 32'(sa % sbv));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b);
    logic is_div;
    is_div = o[2];
    if (is_div && (b == 0)) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!is_div) return 1;
`endif
    return XLEN + 1;
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic start_op(input logic [2:0] o, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input bit push);
    int waited = 0;
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", in_ready, 1);
    op       = o;
    src_a    = a;
    src_b    = b;
    in_valid = 1'b1;
    @(posedge clk);
    if (push) sb_q.push_back('{res: model(o, a, b), lat: model_lat(o, a, b)});
    @(negedge clk);
    in_valid = 1'b0;
    check("accepted_busy", busy, 1);
  endtask

  task automatic finish_op(input int hold);
    sb_entry_t e;
    int        lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (sb_q.size() == 0) begin
      check("sb_underflow", sb_q.size(), 1);
      return;
    end
    e = sb_q.pop_front();
    check("latency", lat, e.lat);
    check("result", result, e.res);
    check("zero_flag", zero_flag, (e.res == 0));
    check("negative_flag", negative_flag, e.res[XLEN-1]);
    check("done_in_ready", in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_result", result, e.res);
      check("hold_flags", {zero_flag, negative_flag}, {(e.res == 0), e.res[XLEN-1]});
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_idle", {in_ready, out_valid}, 2'b10);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input int hold);
    start_op(o, a, b, 1'b1);
    finish_op(hold);
  endtask

  initial begin
    logic [2:0]      ro;
    logic [XLEN-1:0] ra;
    logic [XLEN-1:0] rb;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    op        = 3'd0;
    src_a     = '0;
    src_b     = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_flags", {zero_flag, negative_flag}, 2'b10);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Multiply of the most negative values
    do_op(MD_MULH, 32'h8000_0000, 32'h8000_0000, 0);
    do_op(MD_MUL,  32'h8000_0000, 32'h8000_0000, 0);

    // Signed and unsigned divide/remainder
    do_op(MD_DIV,  32'hFFFF_FFF9, 32'd2, 0);
    do_op(MD_REM,  32'hFFFF_FFF9, 32'd2, 0);
    do_op(MD_DIVU, 32'd100, 32'd7, 0);
    do_op(MD_REMU, 32'd100, 32'd7, 0);

    // Special cases
    do_op(MD_DIVU, 32'h1234, 32'd0, 0);
    do_op(MD_REM,  32'd7, 32'd0, 0);
    do_op(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(MD_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Back-pressure in DONE, then an immediate follow-on accept
    do_op(MD_DIVU, 32'd100, 32'd7, 10);
    do_op(MD_REMU, 32'd100, 32'd7, 0);

    // Asynchronous reset in the middle of CALC (cnt == 15)
    start_op(MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_result", result, 0);
    check("async_rst_flags", {zero_flag, negative_flag}, 2'b10);
    check("async_rst_idle", {in_ready, busy}, 2'b10);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Flush in the middle of CALC (cnt == 15)
    start_op(MD_DIV, 32'h7654_3210, 32'd3, 1'b0);
    repeat (15) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_idle", {in_ready, busy}, 2'b10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("flush_no_valid", out_valid, 0);
    end
    do_op(MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // Flush while IDLE blocks acceptance
    op       = MD_MUL;
    src_a    = 32'd3;
    src_b    = 32'd5;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_idle_block", busy, 0);

    // Multiply latency depends on the build option
    do_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(MD_DIV, 32'd1000, 32'hFFFF_FFFD, 0);

    // Random mix
    for (int i = 0; i < 16; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 6 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      do_op(ro, ra, rb, 0);
    end

    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
